// File: rtl/cw305_trace_regs_pkg.sv
// cw305_trace_regs_pkg: register map, CTRL/STATUS bit positions and ID word
package cw305_trace_regs_pkg;
    localparam int ADDR_ID      = 0;
    localparam int ADDR_CTRL    = 1;
    localparam int ADDR_STATUS  = 2;
    localparam int ADDR_FIFO    = 3;
    localparam int ADDR_PATTERN = 4;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_ARMED   = 3;

    localparam logic [31:0] ID_DEFAULT = 32'h54524331;
endpackage

// File: rtl/cw305_trace_regs_fifo.sv
// trace_fifo_sync: 32-bit synchronous first-word-fall-through FIFO
module trace_fifo_sync #(
    parameter int pFIFO_DEPTH = 16
) (
    input  logic                             usb_clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             flush,
    input  logic [31:0]                      din,
    output logic [31:0]                      dout,
    output logic                             empty,
    output logic                             full,
    output logic [$clog2(pFIFO_DEPTH):0]     count
);
    localparam int AW = $clog2(pFIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   mem [pFIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_wr, do_rd;

    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = count == PW'(pFIFO_DEPTH);
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);

    // storage array: no reset needed, contents are qualified by the pointers
    always_ff @(posedge usb_clk) begin
        if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    // pointers: flush empties the FIFO and overrides any same-cycle push/pop
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/cw305_trace_regs.sv
// cw305_trace_regs: project register block with trace FIFO behind the CW305 USB front-end
module cw305_trace_regs
    import cw305_trace_regs_pkg::*;
#(
    parameter int          pADDR_WIDTH   = 21,
    parameter int          pBYTECNT_SIZE = 7,
    parameter int          pFIFO_DEPTH   = 16,
    parameter logic [31:0] pID           = ID_DEFAULT
) (
    input  logic                                 usb_clk,
    input  logic                                 rst_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           reg_datao,
    output logic [7:0]                           reg_datai,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    input  logic [31:0]                          trace_data,
    input  logic                                 trace_valid,
    output logic                                 armed,
    output logic [31:0]                          trig_pattern
);
    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int CW = $clog2(pFIFO_DEPTH) + 1;

    logic          read_q, write_q, pop_sel_q, overflow;
    logic [23:0]   shadow;
    logic [31:0]   dout;
    logic          empty, full;
    logic [CW-1:0] count;
    logic [8:0]    count9;
    logic [7:0]    count_sat, status0, rdata;
    logic [1:0]    b;
    logic          low4, b0, wr_stb, ctrl_wr, pat_wr, flush, clr_ovf;
    logic          sel_fifo3, pop, push_req, push, ovf_set;

    assign b         = reg_bytecnt[1:0];
    assign low4      = reg_bytecnt < pBYTECNT_SIZE'(4);
    assign b0        = reg_bytecnt == '0;
    assign wr_stb    = reg_write & ~write_q & reg_addrvalid;
    assign ctrl_wr   = wr_stb & (reg_address == AW'(ADDR_CTRL)) & b0;
    assign pat_wr    = wr_stb & (reg_address == AW'(ADDR_PATTERN)) & low4;
    assign flush     = ctrl_wr & reg_datao[CTRL_FLUSH];
    assign clr_ovf   = ctrl_wr & reg_datao[CTRL_CLR_OVF];
    assign sel_fifo3 = reg_addrvalid & (reg_address == AW'(ADDR_FIFO)) & (reg_bytecnt == pBYTECNT_SIZE'(3));
    assign pop       = read_q & ~reg_read & pop_sel_q & ~empty;
    assign push_req  = trace_valid & armed & ~flush;
    assign push      = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;
    assign count9    = 9'(count);
    assign count_sat = count9[8] ? 8'hff : count9[7:0];

    trace_fifo_sync #(.pFIFO_DEPTH(pFIFO_DEPTH)) u_fifo (
        .usb_clk (usb_clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (trace_data),
        .dout    (dout),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    // read mux: anything unmapped, out of width or not address-valid reads zero
    always_comb begin
        status0             = '0;
        status0[STAT_EMPTY] = empty;
        status0[STAT_FULL]  = full;
        status0[STAT_OVF]   = overflow;
        status0[STAT_ARMED] = armed;
        rdata               = '0;
        if (reg_addrvalid && low4) begin
            case (reg_address)
                AW'(ADDR_ID):      rdata = pID[8*b +: 8];
                AW'(ADDR_CTRL):    rdata = b0 ? {7'b0, armed} : 8'h00;
                AW'(ADDR_STATUS):  rdata = b == 2'd0 ? status0 : b == 2'd1 ? count_sat : 8'h00;
                AW'(ADDR_FIFO):    rdata = empty ? 8'h00 : dout[8*b +: 8];
                AW'(ADDR_PATTERN): rdata = trig_pattern[8*b +: 8];
                default:           rdata = '0;
            endcase
        end
    end

    // edge detectors, registered read data, control/overflow and pattern shadow/commit
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            pop_sel_q    <= 1'b0;
            reg_datai    <= '0;
            armed        <= 1'b0;
            overflow     <= 1'b0;
            shadow       <= '0;
            trig_pattern <= '0;
        end else begin
            read_q   <= reg_read;
            write_q  <= reg_write;
            overflow <= ovf_set | (overflow & ~clr_ovf);
            if (reg_read) begin
                reg_datai <= rdata;
                pop_sel_q <= sel_fifo3;
            end
            if (ctrl_wr) armed <= reg_datao[CTRL_ARM];
            if (pat_wr) begin
                if (b == 2'd3) trig_pattern <= {reg_datao, shadow};
                else shadow[8*b +: 8] <= reg_datao;
            end
        end
    end
endmodule

// File: doc/cw305_trace_regs.md
# cw305_trace_regs

Project register block sitting directly downstream of the CW305 USB register front-end. It consumes the front-end's decoded `reg_*` strobes, implements control/status/pattern registers, and drives the read-data byte back to the front-end. It also buffers 32-bit trace words from the capture logic in a small synchronous FIFO that the host drains byte-by-byte through a data register.

## Interface
Parameters
- `pADDR_WIDTH`, 21: full USB address width; must match the front-end.
- `pBYTECNT_SIZE`, 7: byte-select width; `reg_address` is `pADDR_WIDTH-pBYTECNT_SIZE` bits.
- `pFIFO_DEPTH`, 16: trace FIFO depth in words; power of two, 2..256.
- `pID`, 32'h54524331: read-only identification word.

Ports
- `usb_clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg_address`  in  `pADDR_WIDTH-pBYTECNT_SIZE`  register select.
- `reg_bytecnt`  in  `pBYTECNT_SIZE`  byte within register; byte 0 = LSB.
- `reg_datao`  in  8  write data.
- `reg_datai`  out  8  read data to front-end.
- `reg_read`  in  1  level read flag.
- `reg_write`  in  1  level write flag.
- `reg_addrvalid`  in  1  gates all decode.
- `trace_data`  in  32  capture word.
- `trace_valid`  in  1  push request, one word per cycle.
- `armed`  out  1  CTRL.arm.
- `trig_pattern`  out  32  committed pattern.

## Operation
- Register map (`reg_address`):
  - 0 ID, RO, 4 B.
  - 1 CTRL, RW, 1 B: bit0 arm (stored); bit1 flush, bit2 clr_ovf (self-clearing, read 0).
  - 2 STATUS, RO, 2 B: byte0 = {4'b0, armed, overflow, full, empty}; byte1 = FIFO count (saturates at 255).
  - 3 FIFO_DATA, RO, 4 B: head word.
  - 4 TRIG_PATTERN, RW, 4 B, shadowed.
- Unmapped addresses, bytes beyond register width, or `reg_addrvalid`=0: read 0x00, writes ignored.
- Write action fires once per access on the rising edge of `reg_write`; a held level does not repeat.
- TRIG_PATTERN: bytes 0-2 land in a shadow register; byte 3 write loads `trig_pattern` with {datao, shadow[23:0]} in one cycle; reads return the committed value.
- Push: `trace_valid & armed & ~full` writes the word. `trace_valid & armed & full` drops the word and sets sticky `overflow`. Not armed: ignored silently.
- Pop: on the falling edge of `reg_read` when the read targeted FIFO_DATA byte 3 and FIFO not empty. Lower bytes never pop. An empty FIFO reads 0 and does not pop.
- Simultaneous events:
  - Push and pop in the same cycle while full: both occur, count unchanged.
  - Flush and push in the same cycle: flush wins, word dropped, overflow not set.
  - clr_ovf and a new overflow in the same cycle: overflow stays set.

## Timing
- `reg_datai` is registered: updated every cycle `reg_read` is high from current address/bytecnt. Valid one cycle after `reg_read` rises and stable while it stays high; holds last value otherwise.
- Write effect is visible on read-back from the cycle after the `reg_write` rising edge.
- FIFO is first-word-fall-through: a word pushed at edge N is readable at FIFO_DATA from edge N+1.
- empty/full/count update one cycle after push/pop/flush.
- Reset (async assert, sync-released by the existing top-level reset logic):
  - `reg_datai`=0, `armed`=0, `trig_pattern`=0, shadow=0, overflow=0.
  - FIFO empty; edge detectors cleared.
- Reset mid-read: `reg_datai` returns to 0 and no pop occurs.

## Structure
- Shared package: register address constants, CTRL/STATUS bit indices, `pID`.
- Sub-module `trace_fifo_sync`: 32-bit synchronous FWFT FIFO.
  - Inputs: push, pop, flush.
  - Outputs: dout, empty, full, count.
  - Pointer width `$clog2(pFIFO_DEPTH)+1`.
- Top contains decode, edge detectors, shadow/commit, read mux, and overflow logic.

## Test plan
- Read ID bytes 0..3 -> 0x31, 0x43, 0x52, 0x54, each valid one cycle after `reg_read` rises; unmapped address 9 -> 0x00.
- Write TRIG_PATTERN bytes 0..2 = 0xAA, 0xBB, 0xCC:
  - `trig_pattern` stays 0.
  - Then byte 3 = 0xDD -> `trig_pattern`=0xDDCCBBAA next cycle.
- Arm, push 0x11223344 and 0x55667788:
  - STATUS byte1 = 2.
  - Reading FIFO_DATA bytes 0..3 returns 0x44, 0x33, 0x22, 0x11 with a single pop after byte 3.
  - Next word 0x55667788 is presented.
- Arm, push 17 words at depth 16:
  - full=1, overflow=1, count=16.
  - Write CTRL=0x05 -> overflow=0, armed=1.
  - Write CTRL=0x03 -> empty=1, count=0.
- Full FIFO, push and pop in the same cycle -> count stays 16, no overflow; flush concurrent with push -> empty, overflow unchanged.
- Assert `rst_n`=0 mid-read of FIFO_DATA byte 3 -> `reg_datai`=0, FIFO empty, `armed`=0, no spurious pop after release.
